// File: rtl/upload_bus_arbiter.sv
// rtl/upload_bus_arbiter.sv - round-robin arbiter sharing the CDC upload bus between protocol handlers
// Grants are locked per packet; a burst watchdog revokes grants from hung handlers.
module upload_bus_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int IDLE_GAP  = 1,
  parameter int MAX_BURST = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_SRC-1:0]   src_req,
  input  logic [NUM_SRC*8-1:0] src_data,
  input  logic [NUM_SRC*8-1:0] src_source,
  input  logic [NUM_SRC-1:0]   src_valid,
  output logic [NUM_SRC-1:0]   src_ready,
  output logic                 upload_active,
  output logic                 upload_req,
  output logic [7:0]           upload_data,
  output logic [7:0]           upload_source,
  output logic                 upload_valid,
  input  logic                 upload_ready,
  output logic [2:0]           grant_id,
  output logic                 timeout_err
);

  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);
  localparam logic [GW-1:0] GAP_LAST   = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [1:0]           state;
  logic [2:0]           ptr;
  logic [NUM_SRC-1:0]   mask;
  logic [BW-1:0]        burst_cnt;
  logic [GW-1:0]        gap_cnt;

  logic [NUM_SRC-1:0]   eligible;
  logic [2*NUM_SRC-1:0] eligible_dbl;
  logic [NUM_SRC-1:0]   rot;
  logic                 pick_valid;
  logic [2:0]           pick;
  logic                 wd_expire;

  assign eligible     = src_req & ~mask;
  // Doubling the request vector turns the rotate-by-(ptr+1) into a plain shift.
  assign eligible_dbl = {eligible, eligible} >> ({1'b0, ptr} + 4'd1);
  assign rot          = eligible_dbl[NUM_SRC-1:0];

  always_comb begin
    int w;
    pick_valid = 1'b0;
    pick       = ptr;
    w          = 0;
    for (int j = NUM_SRC - 1; j >= 0; j--) begin
      if (rot[j]) begin
        w = int'(ptr) + 1 + j;
        if (w >= NUM_SRC) w = w - NUM_SRC;
        pick_valid = 1'b1;
        pick       = 3'(w);
      end
    end
  end

  assign upload_active = (state == ST_GRANT);

  always_comb begin
    upload_req    = 1'b0;
    upload_valid  = 1'b0;
    upload_data   = 8'h00;
    upload_source = 8'h00;
    src_ready     = '0;
    if (state == ST_GRANT) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (grant_id == 3'(i)) begin
          upload_req    = src_req[i];
          upload_valid  = src_valid[i];
          upload_data   = src_data[8*i +: 8];
          upload_source = src_source[8*i +: 8];
          src_ready[i]  = upload_ready;
        end
      end
    end
  end

  assign wd_expire = (MAX_BURST != 0) && (burst_cnt == BURST_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= 3'(NUM_SRC - 1);
      mask        <= '0;
      burst_cnt   <= '0;
      gap_cnt     <= '0;
      grant_id    <= 3'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      mask        <= mask & src_req;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_id  <= pick;
            ptr       <= pick;
            burst_cnt <= '0;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (burst_cnt != {BW{1'b1}}) burst_cnt <= burst_cnt + 1'b1;
          // A release in the expiry cycle wins: no error and no mask.
          if (!upload_req || wd_expire) begin
            if (upload_req) begin
              timeout_err <= 1'b1;
              mask        <= (mask & src_req) | (NUM_SRC'(1) << grant_id);
            end
            gap_cnt <= '0;
            state   <= (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          else gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_upload_bus_arbiter.sv
// tb/tb_upload_bus_arbiter.sv - directed self-checking bench for upload_bus_arbiter
module tb_upload_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src_req;
  logic [31:0] src_data;
  logic [31:0] src_source;
  logic [3:0]  src_valid;
  logic [3:0]  src_ready;
  logic        upload_active;
  logic        upload_req;
  logic [7:0]  upload_data;
  logic [7:0]  upload_source;
  logic        upload_valid;
  logic        upload_ready;
  logic [2:0]  grant_id;
  logic        timeout_err;

  int n_checks = 0;
  int n_pass   = 0;

  upload_bus_arbiter #(.NUM_SRC(4), .IDLE_GAP(1), .MAX_BURST(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_req(src_req), .src_data(src_data), .src_source(src_source),
    .src_valid(src_valid), .src_ready(src_ready),
    .upload_active(upload_active), .upload_req(upload_req),
    .upload_data(upload_data), .upload_source(upload_source),
    .upload_valid(upload_valid), .upload_ready(upload_ready),
    .grant_id(grant_id), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_grant(input string tag);
    int n;
    n = 0;
    while (!upload_active && n < 40) begin
      step();
      smp();
      n++;
    end
    check(tag, {31'd0, upload_active}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    src_req      = 4'b0000;
    src_valid    = 4'b0000;
    upload_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
  endtask

  int          hs;
  int          n;
  logic        any_active;
  logic [2:0]  exp_order [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
  logic [2:0]  g;

  initial begin
    src_data   = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    src_source = {8'h53, 8'h52, 8'h51, 8'h50};

    // 1: reset state, single handler, 3 bytes, one gap cycle
    do_reset();
    rst_n = 1'b0;
    #2;
    check("rst_active", {31'd0, upload_active}, 32'd0);
    check("rst_ready", {28'd0, src_ready}, 32'd0);
    check("rst_gid", {29'd0, grant_id}, 32'd0);
    check("rst_terr", {31'd0, timeout_err}, 32'd0);
    check("rst_data", {24'd0, upload_data}, 32'd0);
    step();
    rst_n     = 1'b1;
    src_req   = 4'b0001;
    src_valid = 4'b0001;
    smp();
    check("t1_latency0", {31'd0, upload_active}, 32'd0);
    step();
    smp();
    check("t1_active", {31'd0, upload_active}, 32'd1);
    check("t1_gid", {29'd0, grant_id}, 32'd0);
    check("t1_data", {16'd0, upload_source, upload_data}, 32'h50D0);
    check("t1_ready", {28'd0, src_ready}, 32'b0001);
    hs = 0;
    for (int i = 0; i < 3; i++) begin
      if (upload_valid && upload_ready && src_ready[0]) hs++;
      if (i < 2) begin step(); smp(); end
    end
    check("t1_bytes", hs, 3);
    step();
    src_req   = 4'b0000;
    src_valid = 4'b0000;
    smp();
    check("t1_reqdrop", {31'd0, upload_req}, 32'd0);
    step();
    src_req   = 4'b0001;
    src_valid = 4'b0001;
    smp();
    check("t1_gap", {27'd0, upload_active, src_ready}, 32'd0);
    step();
    smp();
    check("t1_idle_after_gap", {31'd0, upload_active}, 32'd0);
    step();
    smp();
    check("t1_regrant", {31'd0, upload_active}, 32'd1);

    // 2: all four requesting, round-robin order
    do_reset();
    src_req   = 4'b1111;
    src_valid = 4'b1111;
    smp();
    for (int k = 0; k < 5; k++) begin
      wait_grant("t2_wait");
      g = exp_order[k];
      check("t2_order", {29'd0, grant_id}, {29'd0, g});
      check("t2_data", {24'd0, upload_data}, {24'd0, 8'hD0 + 8'(g)});
      check("t2_onehot", {28'd0, src_ready}, {28'd0, 4'b0001 << g});
      step();
      smp();
      step();
      src_req[g]   = 1'b0;
      src_valid[g] = 1'b0;
      smp();
      step();
      src_req[g]   = 1'b1;
      src_valid[g] = 1'b1;
      smp();
    end

    // 3: stall on upload_ready
    do_reset();
    upload_ready = 1'b0;
    src_req      = 4'b0100;
    src_valid    = 4'b0100;
    smp();
    wait_grant("t3_wait");
    check("t3_gid", {29'd0, grant_id}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("t3_stall", {23'd0, upload_valid, src_ready, upload_data[3:0]}, {23'd0, 1'b1, 4'b0000, 4'h2});
      step();
      smp();
    end
    step();
    upload_ready = 1'b1;
    smp();
    check("t3_resume", {27'd0, upload_valid, src_ready}, {27'd0, 1'b1, 4'b0100});
    step();
    src_req   = 4'b0000;
    src_valid = 4'b0000;
    smp();

    // 4: watchdog revokes src 1, src 3 served, src 1 held off until req toggles
    do_reset();
    src_req   = 4'b1010;
    src_valid = 4'b1010;
    smp();
    wait_grant("t4_wait");
    check("t4_gid1", {29'd0, grant_id}, 32'd1);
    n = 0;
    while (upload_active && n < 40) begin
      n++;
      step();
      smp();
    end
    check("t4_burst_len", n, 16);
    check("t4_terr", {31'd0, timeout_err}, 32'd1);
    step();
    smp();
    check("t4_terr_pulse", {31'd0, timeout_err}, 32'd0);
    wait_grant("t4_wait3");
    check("t4_gid3", {29'd0, grant_id}, 32'd3);
    step();
    src_req[3]   = 1'b0;
    src_valid[3] = 1'b0;
    smp();
    any_active = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      smp();
      if (upload_active) any_active = 1'b1;
    end
    check("t4_masked", {31'd0, any_active}, 32'd0);
    step();
    src_req[1] = 1'b0;
    smp();
    step();
    src_req[1] = 1'b1;
    smp();
    wait_grant("t4_wait1");
    check("t4_regrant1", {29'd0, grant_id}, 32'd1);

    // 5: release in the watchdog expiry cycle
    do_reset();
    src_req   = 4'b0001;
    src_valid = 4'b0001;
    smp();
    wait_grant("t5_wait");
    for (int i = 0; i < 14; i++) begin
      step();
      smp();
    end
    step();
    src_req   = 4'b0000;
    src_valid = 4'b0000;
    smp();
    check("t5_last_cycle", {31'd0, upload_active}, 32'd1);
    step();
    smp();
    check("t5_no_terr", {30'd0, timeout_err, upload_active}, 32'd0);

    // 6: asynchronous reset mid-grant
    do_reset();
    src_req   = 4'b0100;
    src_valid = 4'b0100;
    smp();
    wait_grant("t6_wait");
    check("t6_gid2", {29'd0, grant_id}, 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_async", {23'd0, upload_active, upload_valid, src_ready, grant_id}, 32'd0);
    check("t6_async_data", {16'd0, upload_data, upload_source}, 32'd0);
    src_req   = 4'b0101;
    src_valid = 4'b0101;
    step();
    rst_n = 1'b1;
    smp();
    wait_grant("t6_wait0");
    check("t6_first_src0", {29'd0, grant_id}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
